// File: rtl/uart_tx.sv
// uart_tx: UART transmitter clocked at the baud rate (one bit period per clock cycle).
// Serialises a parallel word as: start bit (0), WIDTH data bits LSB first, an optional
// parity bit, then a stop bit (1). The line idles high.
//
// Optional feature (macro UART_TX_TWO_STOP_EN): when defined, a second stop-bit state
// follows the first and the frame grows by one cycle. When undefined, no such state exists.
//
// Ports:
//   i_clk            baud-rate clock
//   i_rst_n          asynchronous active-low reset
//   i_parallel_data  word to transmit, sampled with i_data_valid in IDLE
//   i_data_valid     one-cycle accept strobe; ignored while o_busy is high
//   i_parity_enable  1 = append a parity bit after the data bits (latched at accept)
//   i_parity_type    0 = even, 1 = odd (latched at accept)
//   o_serial_data    serial line, registered, idle high
//   o_busy           registered, high from the start bit through the last stop bit
module uart_tx #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_parallel_data,
  input  logic             i_data_valid,
  input  logic             i_parity_enable,
  input  logic             i_parity_type,
  output logic             o_serial_data,
  output logic             o_busy
);

`ifdef UART_TX_TWO_STOP_EN
  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop, StStop2
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop
  } state_e;
`endif

  localparam logic [CNT_WIDTH-1:0] LastBit = CNT_WIDTH'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 serial_q, serial_d;
  logic                 busy_q, busy_d;

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    case (state_q)
      StIdle: begin
        if (i_data_valid) begin
          data_d    = i_parallel_data;
          par_en_d  = i_parity_enable;
          // Even parity = XOR of the data; odd parity inverts it.
          par_bit_d = (^i_parallel_data) ^ i_parity_type;
          state_d   = StStart;
        end
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StData;
      end
      StData: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastBit) begin
          state_d = par_en_q ? StParity : StStop;
        end
      end
      StParity: state_d = StStop;
`ifdef UART_TX_TWO_STOP_EN
      StStop:   state_d = StStop2;
      StStop2:  state_d = StIdle;
`else
      StStop:   state_d = StIdle;
`endif
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so that the output flops line up with the
  // state register: the value visible in a cycle belongs to the state of that cycle.
  always_comb begin
    serial_d = 1'b1;
    busy_d   = 1'b0;
    case (state_d)
      StStart: begin
        serial_d = 1'b0;
        busy_d   = 1'b1;
      end
      StData: begin
        serial_d = data_d[cnt_d];
        busy_d   = 1'b1;
      end
      StParity: begin
        serial_d = par_bit_d;
        busy_d   = 1'b1;
      end
      StStop: begin
        serial_d = 1'b1;
        busy_d   = 1'b1;
      end
`ifdef UART_TX_TWO_STOP_EN
      StStop2: begin
        serial_d = 1'b1;
        busy_d   = 1'b1;
      end
`endif
      default: begin
        serial_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      serial_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      serial_q  <= serial_d;
      busy_q    <= busy_d;
    end
  end

  assign o_serial_data = serial_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx. A table of directed frames with hand-computed
// line patterns (start + data + optional parity), plus hand-written sequences for reset,
// dropped mid-frame strobes, held valid and reset during a frame.
module tb_uart_tx;
  localparam int unsigned WIDTH = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int Stops = 2;
`else
  localparam int Stops = 1;
`endif

  logic             i_clk;
  logic             i_rst_n;
  logic [WIDTH-1:0] i_parallel_data;
  logic             i_data_valid;
  logic             i_parity_enable;
  logic             i_parity_type;
  logic             o_serial_data;
  logic             o_busy;

  int checks;
  int failures;

  uart_tx #(.WIDTH(WIDTH)) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_parallel_data (i_parallel_data),
    .i_data_valid    (i_data_valid),
    .i_parity_enable (i_parity_enable),
    .i_parity_type   (i_parity_type),
    .o_serial_data   (o_serial_data),
    .o_busy          (o_busy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // bits[i] is the expected line value i cycles after the start bit (bit 0 = start bit);
  // len covers start + data + parity, stop bits are checked separately.
  typedef struct {
    logic [7:0]  data;
    logic        pen;
    logic        ptype;
    int          len;
    logic [11:0] bits;
  } vec_t;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Present a word, let one rising edge accept it, then scramble every input so that any
  // failure to latch configuration shows up in the frame.
  task automatic send(input logic [7:0] d, input logic pe, input logic pt);
    i_parallel_data = d;
    i_parity_enable = pe;
    i_parity_type   = pt;
    i_data_valid    = 1'b1;
    @(posedge i_clk);
    #1;
    i_data_valid    = 1'b0;
    i_parallel_data = ~d;
    i_parity_enable = ~pe;
    i_parity_type   = ~pt;
  endtask

  // inj >= 0: raise a one-cycle strobe with 0xC3 after body cycle inj (must be < len-1).
  // hold: raise valid with 0x55 from the last stop cycle and leave it high.
  task automatic check_frame(input string name, input logic [11:0] bits, input int len,
                             input int inj, input bit hold);
    for (int i = 0; i < len; i++) begin
      @(negedge i_clk);
      chk($sformatf("%s_line%0d", name, i), o_serial_data, bits[i]);
      chk($sformatf("%s_busy%0d", name, i), o_busy, 1'b1);
      if (i == inj) begin
        i_data_valid    = 1'b1;
        i_parallel_data = 8'hC3;
      end
      if (i == inj + 1) i_data_valid = 1'b0;
    end
    for (int s = 0; s < Stops; s++) begin
      @(negedge i_clk);
      chk($sformatf("%s_stop%0d", name, s), o_serial_data, 1'b1);
      chk($sformatf("%s_stopbusy%0d", name, s), o_busy, 1'b1);
      if (hold && s == Stops - 1) begin
        i_data_valid    = 1'b1;
        i_parallel_data = 8'h55;
        i_parity_enable = 1'b0;
        i_parity_type   = 1'b0;
      end
    end
    @(negedge i_clk);
    chk($sformatf("%s_idle_line", name), o_serial_data, 1'b1);
    chk($sformatf("%s_idle_busy", name), o_busy, 1'b0);
  endtask

  vec_t        vecs [7];
  logic [11:0] a5_bits;

  initial begin
    checks   = 0;
    failures = 0;
    // 0xA5 LSB first = 1,0,1,0,0,1,0,1; four ones -> even parity 0, odd parity 1.
    vecs[0] = '{data: 8'hA5, pen: 1'b0, ptype: 1'b0, len: 9,  bits: 12'h14A};
    vecs[1] = '{data: 8'hA5, pen: 1'b1, ptype: 1'b0, len: 10, bits: 12'h14A};
    vecs[2] = '{data: 8'hA5, pen: 1'b1, ptype: 1'b1, len: 10, bits: 12'h34A};
    // 0x07: three ones -> odd parity bit 0.
    vecs[3] = '{data: 8'h07, pen: 1'b1, ptype: 1'b1, len: 10, bits: 12'h00E};
    vecs[4] = '{data: 8'h3C, pen: 1'b0, ptype: 1'b1, len: 9,  bits: 12'h078};
    vecs[5] = '{data: 8'h00, pen: 1'b1, ptype: 1'b0, len: 10, bits: 12'h000};
    // 0xFF: eight ones -> odd parity bit 1.
    vecs[6] = '{data: 8'hFF, pen: 1'b1, ptype: 1'b1, len: 10, bits: 12'h3FE};

    i_rst_n         = 1'b1;
    i_parallel_data = '0;
    i_data_valid    = 1'b0;
    i_parity_enable = 1'b0;
    i_parity_type   = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    chk("reset_line", o_serial_data, 1'b1);
    chk("reset_busy", o_busy, 1'b0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      chk($sformatf("quiet_line%0d", c), o_serial_data, 1'b1);
      chk($sformatf("quiet_busy%0d", c), o_busy, 1'b0);
    end

    for (int v = 0; v < 7; v++) begin
      send(vecs[v].data, vecs[v].pen, vecs[v].ptype);
      check_frame($sformatf("vec%0d", v), vecs[v].bits, vecs[v].len, -1, 1'b0);
    end

    // 0xC3 strobed during DATA must be dropped; valid then held with 0x55 from the last
    // stop cycle must start the next frame after exactly one idle cycle.
    send(8'h3C, 1'b0, 1'b0);
    check_frame("drop", 12'h078, 9, 3, 1'b1);
    @(posedge i_clk);
    #1;
    i_data_valid = 1'b0;
    check_frame("held55", 12'h0AA, 9, -1, 1'b0);

    // Reset while data bit 4 is on the line.
    a5_bits = 12'h14A;
    send(8'hA5, 1'b0, 1'b0);
    for (int i = 0; i <= 5; i++) begin
      @(negedge i_clk);
      chk($sformatf("abort_line%0d", i), o_serial_data, a5_bits[i]);
    end
    #2 i_rst_n = 1'b0;
    #1;
    chk("abort_async_line", o_serial_data, 1'b1);
    chk("abort_async_busy", o_busy, 1'b0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge i_clk);
      chk($sformatf("abort_idle_line%0d", c), o_serial_data, 1'b1);
      chk($sformatf("abort_idle_busy%0d", c), o_busy, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
